// File: rtl/mux_arb_nto1_if.sv
// mux_arb_nto1_if: producer/consumer bundle for the N-to-1 arbitrating mux.
// master = the side driving channel data and out_ready (producers/consumer model),
// slave  = the mux itself.
// Optional packet-lock sideband (in_last/out_last) exists only with MUX_ARB_LOCK_EN.
interface mux_arb_nto1_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CH    = 16,
   parameter int unsigned SELW  = 4
) ();
   logic [CH-1:0]       in_valid;
   logic [CH*WIDTH-1:0] in_data;
   logic [CH-1:0]       in_ready;
   logic                out_valid;
   logic [WIDTH-1:0]    out_data;
   logic [SELW-1:0]     out_ch;
   logic                out_ready;
`ifdef MUX_ARB_LOCK_EN
   logic [CH-1:0]       in_last;
   logic                out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_ch, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_ch, out_last
   );
`else
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
`endif
endinterface

// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: registered CH-to-1 datapath mux with valid/ready handshake.
// mode_i=0 selects channel sel_i; mode_i=1 round-robins among valid channels.
// One-entry output register; a drain and a load can happen in the same cycle.
// Define MUX_ARB_LOCK_EN to add packet lock (in_last/out_last): a round-robin
// grant stays on one channel until that channel delivers its last beat.
module mux_arb_nto1 #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CH    = 16,
   parameter int unsigned SELW  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en_i,
   input  logic            mode_i,
   input  logic [SELW-1:0] sel_i,
   mux_arb_nto1_if.slave   bus
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  out_ch_q,    out_ch_d;
   logic [SELW-1:0]  ptr_q,       ptr_d;

   logic             slot_free;
   logic             accept;
   logic             dir_hit;
   logic             rr_hit;
   logic [SELW-1:0]  rr_idx;
   logic [2*CH-1:0]  rr_dbl;
   logic [CH-1:0]    rr_rot;
   int unsigned      rr_gi;
   logic             g_hit;
   logic [SELW-1:0]  g_idx;
   logic [CH-1:0]    g_oh;
   logic [WIDTH-1:0] g_data;

`ifdef MUX_ARB_LOCK_EN
   typedef enum logic {IDLE, LOCKED} lock_st_e;

   lock_st_e         state_q;
   logic [SELW-1:0]  lock_ch_q;
   logic             lock_hit;
   logic             g_last;
   logic             out_last_q, out_last_d;
`endif

   // Directed grant: matching by compare means an out-of-range sel_i never hits.
   always_comb begin
      dir_hit = 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
         if (SELW'(i) == sel_i) dir_hit = bus.in_valid[i];
      end
   end

   // Round-robin grant: rotate valids so bit 0 is channel ptr+1, take first set bit.
   always_comb begin
      rr_dbl = {bus.in_valid, bus.in_valid};
      rr_rot = CH'(rr_dbl >> (32'(ptr_q) + 32'd1));
      rr_hit = 1'b0;
      rr_idx = '0;
      rr_gi  = 0;
      for (int unsigned j = 0; j < CH; j++) begin
         if (!rr_hit && rr_rot[j]) begin
            rr_hit = 1'b1;
            rr_gi  = 32'(ptr_q) + 32'd1 + j;
            if (rr_gi >= CH) rr_gi = rr_gi - CH;
            rr_idx = SELW'(rr_gi);
         end
      end
   end

`ifdef MUX_ARB_LOCK_EN
   // Locked-channel validity.
   always_comb begin
      lock_hit = 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
         if (SELW'(i) == lock_ch_q) lock_hit = bus.in_valid[i];
      end
   end
`endif

   // Final grant choice: mode picks directed or round-robin; a held lock overrides both.
   always_comb begin
      g_hit = mode_i ? rr_hit : dir_hit;
      g_idx = mode_i ? rr_idx : sel_i;
`ifdef MUX_ARB_LOCK_EN
      if (state_q == LOCKED) begin
         g_hit = lock_hit;
         g_idx = lock_ch_q;
      end
`endif
   end

   // Granted channel as one-hot plus its data (and last flag).
   always_comb begin
      g_oh   = '0;
      g_data = '0;
`ifdef MUX_ARB_LOCK_EN
      g_last = 1'b0;
`endif
      for (int unsigned i = 0; i < CH; i++) begin
         if (SELW'(i) == g_idx) begin
            g_oh[i] = g_hit;
            g_data  = bus.in_data[i*WIDTH +: WIDTH];
`ifdef MUX_ARB_LOCK_EN
            g_last  = bus.in_last[i];
`endif
         end
      end
   end

   assign slot_free    = !out_valid_q || bus.out_ready;
   assign accept       = en_i && slot_free && g_hit;
   assign bus.in_ready = accept ? g_oh : '0;

   // Output register next state: load on accept, otherwise drop valid once drained.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
`ifdef MUX_ARB_LOCK_EN
      out_last_d  = out_last_q;
`endif
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = g_data;
         out_ch_d    = g_idx;
`ifdef MUX_ARB_LOCK_EN
         out_last_d  = g_last;
`endif
         if (mode_i) ptr_d = g_idx;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register and round-robin pointer; ptr resets to CH-1 so channel 0 is first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= SELW'(CH - 1);
`ifdef MUX_ARB_LOCK_EN
         out_last_q  <= 1'b0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
`ifdef MUX_ARB_LOCK_EN
         out_last_q  <= out_last_d;
`endif
      end
   end

`ifdef MUX_ARB_LOCK_EN
   // Packet lock: enter on a non-last round-robin accept, leave on last beat or directed mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         lock_ch_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && mode_i && !g_last) begin
                  state_q   <= LOCKED;
                  lock_ch_q <= g_idx;
               end
            end
            LOCKED: begin
               if (!mode_i || (accept && g_last)) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.out_last = out_last_q;
`endif

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// tb_mux_arb_nto1: directed stimulus with a scoreboard queue; a separate monitor
// pops expected beats on every output handshake. Lock scenario runs only when
// MUX_ARB_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_mux_arb_nto1;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned CH    = 16;
   localparam int unsigned SELW  = 4;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SELW-1:0]  ch;
      logic             last;
   } beat_t;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b1;
   logic            en    = 1'b0;
   logic            mode  = 1'b0;
   logic [SELW-1:0] sel   = '0;

   beat_t       exp_q[$];
   beat_t       mon_e;
   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;
   logic [31:0] rr_exp;

   mux_arb_nto1_if #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW)) bus ();

   mux_arb_nto1 #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en),
      .mode_i (mode),
      .sel_i  (sel),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] dat_of(input int unsigned i);
      if (i == 5) return 16'hBEEF;
      return 16'(32'hC000 + i * 17);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int unsigned ch, input logic last = 1'b1);
      exp_q.push_back('{data: dat_of(ch), ch: SELW'(ch), last: last});
   endtask

   // Monitor: just before each rising edge, a valid&ready beat is popped and compared.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_beat: got ch %0d data %h expected none", bus.out_ch, bus.out_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("out_data", 32'(bus.out_data), 32'(mon_e.data));
               check("out_ch",   32'(bus.out_ch),   32'(mon_e.ch));
`ifdef MUX_ARB_LOCK_EN
               check("out_last", 32'(bus.out_last), 32'(mon_e.last));
`endif
            end
         end
      end
   end

   initial begin
      bus.in_valid  = '0;
      bus.out_ready = 1'b0;
      for (int unsigned i = 0; i < CH; i++) bus.in_data[i*WIDTH +: WIDTH] = dat_of(i);
`ifdef MUX_ARB_LOCK_EN
      bus.in_last = '1;
`endif
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_out_data",  32'(bus.out_data),  32'h0);
      check("rst_out_ch",    32'(bus.out_ch),    32'h0);
      check("rst_in_ready",  32'(bus.in_ready),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed grant of channel 5.
      @(negedge clk);
      en = 1'b1; mode = 1'b0; sel = 4'd5; bus.in_valid = 16'h0020; bus.out_ready = 1'b1;
      #1 check("dir_in_ready", 32'(bus.in_ready), 32'h0020);
      push(5);
      @(negedge clk);
      bus.in_valid = '0;
      #1 check("dir_out_valid", 32'(bus.out_valid), 32'h1);

      // Directed select of an invalid channel: no grant.
      @(negedge clk);
      sel = 4'd3; bus.in_valid = 16'h0080;
      #1 check("nogrant_in_ready", 32'(bus.in_ready), 32'h0);
      check("drained_out_valid", 32'(bus.out_valid), 32'h0);
      @(negedge clk);
      #1 check("nogrant_out_valid", 32'(bus.out_valid), 32'h0);

      // Enable low: nothing granted in either mode.
      @(negedge clk);
      en = 1'b0; bus.in_valid = '1; sel = 4'd0;
      #1 check("en0_dir_in_ready", 32'(bus.in_ready), 32'h0);
      mode = 1'b1;
      #1 check("en0_rr_in_ready", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
      #1 check("en0_out_valid", 32'(bus.out_valid), 32'h0);

      // Round-robin fairness over all channels, 20 beats back to back.
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) begin
            en = 1'b1; mode = 1'b1; bus.in_valid = '1;
         end
         #1;
         rr_exp = 32'd1 << (k % 16);
         check("rr_in_ready", 32'(bus.in_ready), rr_exp);
         if (k > 0) check("rr_no_bubble", 32'(bus.out_valid), 32'h1);
         push(k % 16);
      end

      // Back-pressure: load channel 2, stall 3 cycles, then drain+load channel 9.
      @(negedge clk);
      mode = 1'b0; sel = 4'd2; bus.in_valid = 16'h0004;
      #1 check("bp_load_in_ready", 32'(bus.in_ready), 32'h0004);
      push(2);
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         if (s == 0) bus.out_ready = 1'b0;
         #1;
         check("stall_in_ready",  32'(bus.in_ready),  32'h0);
         check("stall_out_valid", 32'(bus.out_valid), 32'h1);
         check("stall_out_data",  32'(bus.out_data),  32'(dat_of(2)));
         check("stall_out_ch",    32'(bus.out_ch),    32'd2);
      end
      @(negedge clk);
      bus.out_ready = 1'b1; sel = 4'd9; bus.in_valid = 16'h0200;
      #1 check("release_in_ready", 32'(bus.in_ready), 32'h0200);
      push(9);
      @(negedge clk);
      bus.in_valid = '0;
      #1 check("release_out_valid", 32'(bus.out_valid), 32'h1);
      check("release_out_ch", 32'(bus.out_ch), 32'd9);

      // Asynchronous reset while a beat is held.
      @(negedge clk);
      sel = 4'd6; bus.in_valid = 16'h0040; bus.out_ready = 1'b0;
      #1 check("pre_rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("pre_rst_in_ready", 32'(bus.in_ready), 32'h0040);
      @(negedge clk);
      bus.in_valid = '0;
      #1 check("held_out_data", 32'(bus.out_data), 32'(dat_of(6)));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("async_rst_out_data",  32'(bus.out_data),  32'h0);
      check("async_rst_out_ch",    32'(bus.out_ch),    32'h0);

      // After reset the first round-robin grant is channel 0, then wrap checks.
      @(negedge clk);
      rst_n = 1'b1; mode = 1'b1; bus.in_valid = '1; bus.out_ready = 1'b1;
      #1 check("post_rst_rr", 32'(bus.in_ready), 32'h0001);
      push(0);
      @(negedge clk);
      bus.in_valid = 16'h8001;
      #1 check("rr_skip_to_15", 32'(bus.in_ready), 32'h8000);
      push(15);
      @(negedge clk);
      #1 check("rr_wrap_to_0", 32'(bus.in_ready), 32'h0001);
      push(0);

`ifdef MUX_ARB_LOCK_EN
      // Packet lock: channel 4 sends 3 beats (last on the third) while channel 1 waits.
      @(negedge clk);
      bus.in_valid = 16'h0008; bus.in_last = 16'h0008;
      #1 check("lock_prep", 32'(bus.in_ready), 32'h0008);
      push(3, 1'b1);
      @(negedge clk);
      bus.in_valid = 16'h0012; bus.in_last = 16'h0002;
      #1 check("lock_beat0", 32'(bus.in_ready), 32'h0010);
      push(4, 1'b0);
      @(negedge clk);
      #1 check("lock_beat1", 32'(bus.in_ready), 32'h0010);
      push(4, 1'b0);
      @(negedge clk);
      bus.in_last = 16'h0012;
      #1 check("lock_beat2", 32'(bus.in_ready), 32'h0010);
      push(4, 1'b1);
      @(negedge clk);
      #1 check("lock_released", 32'(bus.in_ready), 32'h0002);
      push(1, 1'b1);
`endif

      @(negedge clk);
      bus.in_valid = '0;
      repeat (3) @(negedge clk);
      #1 check("queue_empty", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
